// File: rtl/io_debounce_if.sv
// Pin-side bundle for io_debounce: raw board pins and clears in, clean levels and event flags out.
interface io_debounce_if #(
   parameter int N_BITS = 4
);
   logic [N_BITS-1:0] raw_in;
   logic [N_BITS-1:0] event_clr;
   logic [N_BITS-1:0] io_in;
   logic [N_BITS-1:0] rise_pulse;
   logic [N_BITS-1:0] fall_pulse;
   logic [N_BITS-1:0] event_sticky;
   logic [N_BITS-1:0] dbg_pending;

   modport master (
      output raw_in,
      output event_clr,
      input  io_in,
      input  rise_pulse,
      input  fall_pulse,
      input  event_sticky,
      input  dbg_pending
   );

   modport slave (
      input  raw_in,
      input  event_clr,
      output io_in,
      output rise_pulse,
      output fall_pulse,
      output event_sticky,
      output dbg_pending
   );
endinterface

// File: rtl/io_debounce.sv
// Per-bit synchronizer + debounce counter with edge pulses and sticky rise flags.
// Define IO_DEBOUNCE_BYPASS_EN to drop the counters and pass the synchronized level straight through.
module io_debounce #(
   parameter int N_BITS          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         reset,
   io_debounce_if.slave bus
);

   logic [N_BITS-1:0] r_sync [SYNC_STAGES];
   logic [N_BITS-1:0] w_sync;
   logic [N_BITS-1:0] w_io_nxt;
   logic [N_BITS-1:0] w_pending;
   logic [N_BITS-1:0] w_rise_nxt;
   logic [N_BITS-1:0] w_fall_nxt;
   logic [N_BITS-1:0] w_sticky_nxt;
   logic [N_BITS-1:0] r_io;
   logic [N_BITS-1:0] r_rise;
   logic [N_BITS-1:0] r_fall;
   logic [N_BITS-1:0] r_sticky;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= bus.raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IO_DEBOUNCE_BYPASS_EN
   assign w_io_nxt  = w_sync;
   assign w_pending = '0;
`else
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t           r_state     [N_BITS];
   state_t           w_state_nxt [N_BITS];
   logic [CNT_W-1:0] r_cnt       [N_BITS];
   logic [CNT_W-1:0] w_cnt_nxt   [N_BITS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_BITS; i++) begin
            r_state[i] <= ST_STABLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_BITS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   // Any edge where sync matches the accepted level discards the count, so bounces restart it.
   always_comb begin
      w_io_nxt = r_io;
      for (int i = 0; i < N_BITS; i++) begin
         w_state_nxt[i] = ST_STABLE;
         w_cnt_nxt[i]   = '0;
         case (r_state[i])
            ST_STABLE: begin
               if (w_sync[i] != r_io[i]) begin
                  if (CNT_LAST == '0) begin
                     w_io_nxt[i] = w_sync[i];
                  end else begin
                     w_state_nxt[i] = ST_PENDING;
                     w_cnt_nxt[i]   = CNT_ONE;
                  end
               end
            end
            ST_PENDING: begin
               if (w_sync[i] != r_io[i]) begin
                  if (r_cnt[i] == CNT_LAST) begin
                     w_io_nxt[i] = w_sync[i];
                  end else begin
                     w_state_nxt[i] = ST_PENDING;
                     w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
                  end
               end
            end
            default: begin
               w_state_nxt[i] = ST_STABLE;
               w_cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < N_BITS; i++) begin
         w_pending[i] = (r_state[i] == ST_PENDING);
      end
   end
`endif

   // Pulses are computed from the next level so they line up with the cycle io_in changes.
   always_comb begin
      w_rise_nxt   = w_io_nxt & ~r_io;
      w_fall_nxt   = ~w_io_nxt & r_io;
      w_sticky_nxt = (r_sticky & ~bus.event_clr) | w_rise_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_io     <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
         r_sticky <= '0;
      end else begin
         r_io     <= w_io_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_sticky <= w_sticky_nxt;
      end
   end

   assign bus.io_in        = r_io;
   assign bus.rise_pulse   = r_rise;
   assign bus.fall_pulse   = r_fall;
   assign bus.event_sticky = r_sticky;
   assign bus.dbg_pending  = w_pending;

endmodule
